// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: holds the core in reset, runs it for a
// bounded budget and stops on halt (branch-to-self), syscall or timeout.
module mips_run_ctrl #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 350,
    parameter int HALT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_start,
    input  logic [31:0]      i_instruction,
    input  logic [31:0]      i_pc_cur,
    input  logic [31:0]      i_pc_next,
    output logic             o_cpu_rst,
    output logic             o_running,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instr_cnt,
    output logic [31:0]      o_last_pc,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int RST_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HALT_C   = CNT_W'(HALT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
    localparam logic [31:0] INSTR_SYSCALL = 32'h0000_000C;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_SYSCALL = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_t            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  halt_q, halt_d;
    logic [1:0]        status_q, status_d;
    logic [31:0]       last_pc_q, last_pc_d;
    logic              cpu_rst_q, running_q, done_q;
    logic [CNT_W-1:0]  cyc_inc, instr_inc, halt_inc;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign cyc_inc   = (cyc_q   == CNT_SAT) ? cyc_q   : cyc_q   + 1'b1;
    assign instr_inc = (instr_q == CNT_SAT) ? instr_q : instr_q + 1'b1;
    assign halt_inc  = (halt_q  == CNT_SAT) ? halt_q  : halt_q  + 1'b1;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        instr_d   = instr_q;
        halt_d    = halt_q;
        status_d  = status_q;
        last_pc_d = last_pc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_LOAD;
                    cyc_d     = '0;
                    instr_d   = '0;
                    halt_d    = '0;
                    status_d  = ST_NONE;
                end
            end
            S_RESET: begin
                rst_cnt_d = rst_cnt_q - 1'b1;
                if (rst_cnt_q == RST_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cyc_d   = cyc_inc;
                instr_d = (i_instruction != INSTR_NOP) ? instr_inc : instr_q;
                halt_d  = (i_pc_next == i_pc_cur) ? halt_inc : '0;
                // Terminations look at the post-update counters; syscall wins, then halt.
                if (i_instruction == INSTR_SYSCALL) begin
                    state_d  = S_DONE;
                    status_d = ST_SYSCALL;
                end else if (halt_d >= HALT_C) begin
                    state_d  = S_DONE;
                    status_d = ST_HALTED;
                end else if (cyc_d >= MAX_C) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end
                if (state_d == S_DONE) last_pc_d = i_pc_cur;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            instr_q   <= '0;
            halt_q    <= '0;
            status_q  <= ST_NONE;
            last_pc_q <= '0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cyc_q     <= cyc_d;
            instr_q   <= instr_d;
            halt_q    <= halt_d;
            status_q  <= status_d;
            last_pc_q <= last_pc_d;
            cpu_rst_q <= (state_d != S_RUN);
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign o_cpu_rst   = cpu_rst_q;
    assign o_running   = running_q;
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_cycle_cnt = cyc_q;
    assign o_instr_cnt = instr_q;
    assign o_last_pc   = last_pc_q;
    assign o_state     = state_q;

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Parametrised run controller for the single-cycle MIPS core: sequences the core's reset, runs it for a bounded cycle budget, and stops the run on halt (branch-to-self), a `syscall` instruction, or timeout. Sits between the top-level clock/reset and the `MIPS` instance. Consumes the core's instruction and PC taps, and reports status and cycle/instruction counts. It replaces fixed reset pulses and fixed `$finish` delays with a synthesizable, self-terminating sequence usable in simulation and on FPGA.

## Interface
- `RST_CYCLES`, default 2: number of cycles `o_cpu_rst` is held in the RESET state (≥1).
- `MAX_CYCLES`, default 350: RUN-cycle budget before timeout (≥1).
- `HALT_CYCLES`, default 4: consecutive cycles with `i_pc_next == i_pc_cur` that declare a halt (≥1).
- `CNT_W`, default 16: width of the counters; must hold `MAX_CYCLES`.
- `i_clk` in 1: single clock; all state changes on its rising edge.
- `i_arst` in 1: reset, synchronous and active-high.
- `i_start` in 1: start-run request, sampled in IDLE and DONE.
- `i_instruction` in 32: current instruction from the core.
- `i_pc_cur` in 32: current PC from the core.
- `i_pc_next` in 32: next PC from the core.
- `o_cpu_rst` out 1: reset to the core; drives `MIPS.i_arst`.
- `o_running` out 1: high in RUN.
- `o_done` out 1: high in DONE.
- `o_status` out 2: 00 none, 01 halted, 10 syscall, 11 timeout.
- `o_cycle_cnt` out CNT_W: number of RUN cycles elapsed.
- `o_instr_cnt` out CNT_W: number of non-NOP instructions retired in RUN.
- `o_last_pc` out 32: `i_pc_cur` captured on the final RUN cycle.

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- **IDLE**
  - `o_cpu_rst`=1.
  - On `i_start`=1: go to RESET, load the reset counter with `RST_CYCLES`, clear the cycle, instruction and halt counters, and set `o_status`=00.
- **RESET**
  - `o_cpu_rst`=1.
  - Decrement the reset counter each cycle.
  - When it reaches 0: go to RUN. RESET lasts exactly `RST_CYCLES` cycles.
- **RUN**
  - `o_cpu_rst`=0 and `o_running`=1.
  - Every cycle:
    - `o_cycle_cnt` += 1.
    - If `i_instruction` != 32'h0000_0000: `o_instr_cnt` += 1.
    - Halt counter: increments if `i_pc_next == i_pc_cur`, otherwise clears to 0.
  - Termination conditions, evaluated on the current cycle's inputs and counter values after the update:
    - `i_instruction` == 32'h0000_000C → status syscall.
    - Halt counter reaches `HALT_CYCLES` → status halted.
    - `o_cycle_cnt` reaches `MAX_CYCLES` → status timeout.
  - Priority when several conditions coincide: syscall > halted > timeout.
  - On termination: go to DONE and capture `o_last_pc` = `i_pc_cur`.
- **DONE**
  - `o_done`=1 and `o_cpu_rst`=1, so the core is frozen.
  - Counters and status hold their values.
  - `i_start`=1 restarts exactly as from IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap.
- The terminating cycle counts toward both `o_cycle_cnt` and `o_instr_cnt`.

## Timing
- Reset values, while `i_arst`=1 and on the first edge after:
  - State IDLE.
  - `o_cpu_rst`=1.
  - `o_running`=0, `o_done`=0.
  - `o_status`=00.
  - `o_cycle_cnt`=0, `o_instr_cnt`=0.
  - `o_last_pc`=0.
- `i_arst` takes priority over all inputs. Asserting it mid-RUN returns to IDLE on the next edge and asserts `o_cpu_rst` from that edge.
- From `i_start` sampled in IDLE:
  - Edge 1: enter RESET.
  - `o_cpu_rst` falls at edge `1+RST_CYCLES`.
  - `o_running` rises at that same edge.
- Termination detected on RUN cycle k sets `o_done`=1, `o_running`=0 and `o_cpu_rst`=1 at the next edge, with `o_cycle_cnt`=k.
- Latency when no other condition fires: timeout gives `o_cycle_cnt`=`MAX_CYCLES` exactly.
- `i_start` held high in DONE re-arms every time DONE is entered; `i_start` is ignored in RESET and RUN.
- `HALT_CYCLES`=1: a single self-loop cycle terminates the run.

## Test plan
- Reset then `i_start` pulse, `RST_CYCLES`=2 → `o_cpu_rst` high for IDLE plus 2 RESET cycles, `o_running`=1 on the third edge after start.
- PC increments by 4 forever, `MAX_CYCLES`=350 → `o_done`=1, `o_status`=11, `o_cycle_cnt`=350.
- PC stuck at 0x0000_0040 with `i_pc_next`=`i_pc_cur` from RUN cycle 10, `HALT_CYCLES`=4 → `o_status`=01 after cycle 13, `o_last_pc`=0x40, `o_cycle_cnt`=13.
- `i_instruction`=0x0000_000C on the same cycle that the halt count reaches 4 → `o_status`=10.
- 5 NOPs among 20 RUN cycles, then syscall on cycle 21 → `o_instr_cnt`=16, `o_cycle_cnt`=21.
- `i_arst` asserted on RUN cycle 50, released, then `i_start` → counters cleared, full RESET sequence repeated; restart from DONE behaves identically.
